pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined CPU. It carries a control bundle and a data bundle under a valid/ready handshake, with a one-entry skid buffer so that upstream ready is fully registered. It also supports synchronous flush (bubble insertion with control cleared), downstream stall, and saturating performance counters for bubbles, stalls and flushes.

---
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// -----------------------------------------------------------------------------
// Elastic pipeline register placed between CPU stages (IF/ID, ID/EX, EX/MEM,
// MEM/WB). A main entry (M) drives the outputs and a one-entry skid entry (S)
// catches the beat that was already in flight when the downstream side
// stopped. Because of the skid entry, in_ready can come straight from a flop
// and has no combinational path from out_ready or stall.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   flush       kill every held entry and the beat presented this cycle
//   stall       hold the output; blocks the downstream transfer
//   in_valid    upstream beat present
//   in_ready    registered; high whenever the skid entry is empty
//   in_ctrl     upstream control bundle   [CTRL_W]
//   in_data     upstream data bundle      [DATA_W]
//   out_valid   main entry valid
//   out_ready   downstream accepts
//   out_ctrl    control bundle, all-zero whenever out_valid is low
//   out_data    data bundle
//   occupancy   number of held entries, 0..2
//   cnt_clr     synchronous clear of the three counters
//   bubble_cnt  saturating count of cycles with out_valid low
//   stall_cnt   saturating count of cycles with out_valid and stall high
//   flush_cnt   saturating count of flushes that killed a held entry
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 128,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    entry_t mEntry;
    entry_t sEntry;
    entry_t inBeat;
    logic   inReadyQ;
    logic   inFire;
    logic   outFire;
    logic   sValidNext;

    assign inBeat  = '{valid: 1'b1, ctrl: in_ctrl, data: in_data};
    assign inFire  = in_valid & inReadyQ;
    assign outFire = mEntry.valid & out_ready & ~stall;

    // Skid occupancy after a normal (non-flush) update. in_ready is the
    // registered inverse of this, so it never depends on this cycle's
    // out_ready/stall at the output pin.
    // NOTE: every signal written in always_comb gets a default first so no
    // latch is inferred on an unlisted path.
    always_comb begin
        sValidNext = sEntry.valid;
        if (sEntry.valid) begin
            sValidNext = ~outFire;
        end else if (mEntry.valid && !outFire && inFire) begin
            sValidNext = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            mEntry   <= '0;
            sEntry   <= '0;
            inReadyQ <= 1'b1;
        end else if (flush) begin
            // The beat offered this cycle is accepted by the handshake and
            // simply never written anywhere.
            mEntry.valid <= 1'b0;
            mEntry.ctrl  <= '0;
            sEntry.valid <= 1'b0;
            sEntry.ctrl  <= '0;
            // NOTE: data registers are only cleared when CLEAR_DATA is set;
            // otherwise they are left alone to save the wide reset/clear fan-out.
            if (CLEAR_DATA) begin
                mEntry.data <= '0;
                sEntry.data <= '0;
            end
            inReadyQ <= 1'b1;
        end else begin
            if (!mEntry.valid) begin
                if (inFire) begin
                    mEntry <= inBeat;
                end
            end else if (outFire) begin
                if (sEntry.valid) begin
                    // in_ready is low here, so no new beat can collide.
                    mEntry       <= sEntry;
                    sEntry.valid <= 1'b0;
                    sEntry.ctrl  <= '0;
                end else if (inFire) begin
                    mEntry <= inBeat;
                end else begin
                    mEntry.valid <= 1'b0;
                    mEntry.ctrl  <= '0;
                end
            end else if (inFire) begin
                sEntry <= inBeat;
            end
            inReadyQ <= ~sValidNext;
        end
    end

    // Performance counters, saturating; cnt_clr beats increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            if (!mEntry.valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (mEntry.valid && stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            // S valid implies M valid, so M alone tells whether anything is held.
            if (flush && mEntry.valid && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = mEntry.valid;
    assign out_ctrl  = mEntry.ctrl;
    assign out_data  = mEntry.data;
    assign occupancy = {1'b0, mEntry.valid} + {1'b0, sEntry.valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// -----------------------------------------------------------------------------
// Two instances share one stimulus stream: instance A keeps data on flush with
// 16-bit counters, instance B clears data on flush with 4-bit counters. The
// reference is a two-deep FIFO queue plus plain integer counters; it is
// updated once per cycle on the falling edge, after the outputs produced by
// the previous rising edge have been compared against it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 64;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset, flush, stall, in_valid, out_ready, cnt_clr;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          inReadyA, outValidA, inReadyB, outValidB;
    logic [CW-1:0] outCtrlA, outCtrlB;
    logic [DW-1:0] outDataA, outDataB;
    logic [1:0]    occA, occB;
    logic [15:0]   bubA, stlA, flsA;
    logic [3:0]    bubB, stlB, flsB;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .CNT_W(16)) u_dutA (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(inReadyA), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(outValidA), .out_ready(out_ready), .out_ctrl(outCtrlA), .out_data(outDataA),
        .occupancy(occA), .cnt_clr(cnt_clr),
        .bubble_cnt(bubA), .stall_cnt(stlA), .flush_cnt(flsA)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(4)) u_dutB (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(inReadyB), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(outValidB), .out_ready(out_ready), .out_ctrl(outCtrlB), .out_data(outDataB),
        .occupancy(occB), .cnt_clr(cnt_clr),
        .bubble_cnt(bubB), .stall_cnt(stlB), .flush_cnt(flsB)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int satInc(input int v, input int maxVal);
        return (v < maxVal) ? v + 1 : v;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    beat_t       expQ[$];
    logic [DW-1:0] lastA, lastB;   // data left in M once it empties
    int          bA, sA, fA, bB, sB, fB;
    bit          armed = 1'b0;

    always @(negedge clk) begin : scoreboard
        int  sz;
        bit  outFire, inFire;
        sz = expQ.size();

        if (armed) begin
            check("A out_valid", outValidA, sz > 0);
            check("A in_ready",  inReadyA,  sz < 2);
            check("A occupancy", occA, sz);
            check("B out_valid", outValidB, sz > 0);
            check("B in_ready",  inReadyB,  sz < 2);
            check("B occupancy", occB, sz);
            if (sz > 0) begin
                check("A out_ctrl", outCtrlA, expQ[0].ctrl);
                check("A out_data", outDataA, expQ[0].data);
                check("B out_ctrl", outCtrlB, expQ[0].ctrl);
                check("B out_data", outDataB, expQ[0].data);
            end else begin
                check("A bubble ctrl", outCtrlA, 0);
                check("A idle data",   outDataA, lastA);
                check("B bubble ctrl", outCtrlB, 0);
                check("B idle data",   outDataB, lastB);
            end
            check("A bubble_cnt", bubA, bA);
            check("A stall_cnt",  stlA, sA);
            check("A flush_cnt",  flsA, fA);
            check("B bubble_cnt", bubB, bB);
            check("B stall_cnt",  stlB, sB);
            check("B flush_cnt",  flsB, fB);
        end

        // Advance the model to the state after the coming rising edge.
        if (reset) begin
            expQ.delete();
            lastA = '0;
            lastB = '0;
            bA = 0; sA = 0; fA = 0; bB = 0; sB = 0; fB = 0;
            armed = 1'b1;
        end else begin
            if (cnt_clr) begin
                bA = 0; sA = 0; fA = 0; bB = 0; sB = 0; fB = 0;
            end else begin
                if (sz == 0) begin
                    bA = satInc(bA, 65535); bB = satInc(bB, 15);
                end
                if (sz > 0 && stall) begin
                    sA = satInc(sA, 65535); sB = satInc(sB, 15);
                end
                if (flush && sz > 0) begin
                    fA = satInc(fA, 65535); fB = satInc(fB, 15);
                end
            end
            if (flush) begin
                if (sz > 0) lastA = expQ[0].data;
                lastB = '0;
                expQ.delete();
            end else begin
                outFire = (sz > 0) && out_ready && !stall;
                inFire  = in_valid && (sz < 2);
                if (outFire) begin
                    lastA = expQ[0].data;
                    lastB = expQ[0].data;
                    void'(expQ.pop_front());
                end
                if (inFire) expQ.push_back('{ctrl: in_ctrl, data: in_data});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idleInputs();
        flush = 0; stall = 0; in_valid = 0; cnt_clr = 0;
        in_ctrl = '0; in_data = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and keep it up until the handshake completes.
    task automatic sendBeat(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int waited;
        waited   = 0;
        in_valid = 1; in_ctrl = c; in_data = d;
        @(negedge clk);
        while (!inReadyA && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!inReadyA) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 50 cycles", inReadyA);
        end
        nextCycle();
        in_valid = 0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 1; out_ready = 1;
        idleInputs();
        repeat (2) nextCycle();
        reset = 0;
        nextCycle();

        // 8-beat stream at full throughput
        for (int i = 0; i < 8; i++) sendBeat(16'h0001, DW'(i));
        repeat (3) nextCycle();

        // three stall cycles in the middle of a stream
        fork
            for (int i = 0; i < 8; i++) sendBeat(16'h0001, DW'(16 + i));
            begin
                repeat (2) nextCycle();
                stall = 1;
                repeat (3) nextCycle();
                stall = 0;
            end
        join
        repeat (4) nextCycle();

        // flush with both entries full and a beat offered
        out_ready = 0;
        sendBeat(16'h0011, 64'hAAAA_0000_0000_0001);
        sendBeat(16'h0022, 64'hBBBB_0000_0000_0002);
        in_valid = 1; in_ctrl = 16'hFFFF; in_data = 64'hDEAD_BEEF_0000_0003;
        flush = 1;
        nextCycle();
        flush = 0; in_valid = 0;
        repeat (2) nextCycle();

        // flush with one entry held and the offered beat actually accepted
        sendBeat(16'h0033, 64'h3333);
        in_valid = 1; in_ctrl = 16'hFFFF; in_data = 64'h4444;
        flush = 1;
        nextCycle();
        flush = 0; in_valid = 0;
        out_ready = 1;
        repeat (2) nextCycle();

        // flush coinciding with stall on a valid entry
        stall = 1;
        sendBeat(16'h0055, 64'h5555);
        flush = 1;
        nextCycle();
        flush = 0; stall = 0;
        repeat (2) nextCycle();

        // long idle: 4-bit bubble counter saturates, then clear
        repeat (20) nextCycle();
        cnt_clr = 1;
        nextCycle();
        cnt_clr = 0;
        repeat (2) nextCycle();

        // randomized traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 99) < 15);
            flush     = ($urandom_range(0, 99) < 3);
            cnt_clr   = ($urandom_range(0, 199) < 1);
            reset     = ($urandom_range(0, 999) < 3);
            nextCycle();
        end
        reset = 0; out_ready = 1;
        idleInputs();
        repeat (4) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
